// File: rtl/delay_line_pkg.sv
// Shared helpers for the multi-channel delay line: width calculation and delay clamp.
package delay_line_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic int clamp_dly(input int sel, input int max_d);
      return (sel > max_d) ? max_d : sel;
   endfunction

endpackage

// File: rtl/delay_ch_stage.sv
// One channel of the delay line: sample shift register plus the pre-shift tap mux.
module delay_ch_stage
   import delay_line_pkg::*;
#(
   parameter int WIDTH     = 12,
   parameter int DEPTH_MAX = 16,
   parameter int DLY_W     = clog2(DEPTH_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             adv,
   input  logic [WIDTH-1:0] din,
   input  logic [DLY_W-1:0] sel,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] s [DEPTH_MAX];

   // Clear has priority over advance, so a sample presented with a flush is dropped.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int k = 0; k < DEPTH_MAX; k++) s[k] <= '0;
      end else if (adv) begin
         s[0] <= din;
         for (int k = 1; k < DEPTH_MAX; k++) s[k] <= s[k-1];
      end
   end

   // Tap is taken before the shift: sel = D picks the sample accepted D samples ago.
   always_comb begin
      dout = din;
      for (int k = 0; k < DEPTH_MAX; k++) begin
         if (int'(sel) == k + 1) dout = s[k];
      end
   end

endmodule

// File: rtl/delay_line_mc.sv
// Multi-channel, sample-qualified delay line with runtime-selectable depth, flush and bypass.
module delay_line_mc
   import delay_line_pkg::*;
#(
   parameter int WIDTH     = 12,
   parameter int NCH       = 3,
   parameter int DEPTH_MAX = 16,
   parameter int DLY_W     = clog2(DEPTH_MAX + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [DLY_W-1:0]     dly_sel,
   input  logic                 flush,
   output logic                 out_valid,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic                 primed,
   output logic [DLY_W-1:0]     fill_cnt
);

   localparam logic [DLY_W-1:0] CNT_MAX = DLY_W'(DEPTH_MAX);

   logic [DLY_W-1:0]     d_eff;
   logic [NCH*WIDTH-1:0] tap;

   assign d_eff  = DLY_W'(clamp_dly(int'(dly_sel), DEPTH_MAX));
   assign primed = (fill_cnt >= d_eff);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      delay_ch_stage #(
         .WIDTH     (WIDTH),
         .DEPTH_MAX (DEPTH_MAX),
         .DLY_W     (DLY_W)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .clr  (flush),
         .adv  (in_valid),
         .din  (in_data[c*WIDTH +: WIDTH]),
         .sel  (d_eff),
         .dout (tap[c*WIDTH +: WIDTH])
      );
   end

   // Output only counts as valid once enough samples exist for the current depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         fill_cnt  <= '0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         fill_cnt  <= (fill_cnt == CNT_MAX) ? CNT_MAX : fill_cnt + 1'b1;
         out_data  <= tap;
         out_valid <= primed;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_delay_line_mc.sv
// Directed self-checking bench for delay_line_mc with hand-computed expectations.
module tb_delay_line_mc;

   localparam int WIDTH     = 12;
   localparam int NCH       = 3;
   localparam int DEPTH_MAX = 16;
   localparam int DLY_W     = 5;
   localparam int DW        = NCH * WIDTH;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [DLY_W-1:0] dly_sel;
   logic          flush;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          primed;
   logic [DLY_W-1:0] fill_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   delay_line_mc #(
      .WIDTH     (WIDTH),
      .NCH       (NCH),
      .DEPTH_MAX (DEPTH_MAX),
      .DLY_W     (DLY_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .dly_sel   (dly_sel),
      .flush     (flush),
      .out_valid (out_valid),
      .out_data  (out_data),
      .primed    (primed),
      .fill_cnt  (fill_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the clock edge.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic f);
      in_valid = v;
      in_data  = d;
      flush    = f;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input logic [DLY_W-1:0] sel);
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      flush    = 1'b0;
      dly_sel  = sel;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Test 1: default depth 4, counting ramp on ch0
      doReset(5'd4);
      checkOutput("rst_valid", DW'(out_valid), DW'(0));
      checkOutput("rst_data", out_data, DW'(0));
      checkOutput("rst_fill", DW'(fill_cnt), DW'(0));
      checkOutput("rst_primed_d4", DW'(primed), DW'(0));
      for (int n = 1; n <= 20; n++) begin
         applyStimulus(1'b1, DW'(n), 1'b0);
         checkOutput("t1_valid", DW'(out_valid), DW'(n >= 5));
         if (n >= 5) checkOutput("t1_data", out_data, DW'(n - 4));
         checkOutput("t1_fill", DW'(fill_cnt), DW'((n > 16) ? 16 : n));
      end
      checkOutput("t1_primed", DW'(primed), DW'(1));

      // Test 2: bypass
      doReset(5'd0);
      checkOutput("t2_primed_rst", DW'(primed), DW'(1));
      applyStimulus(1'b1, DW'(36'h000ABC000), 1'b0);
      checkOutput("t2_valid", DW'(out_valid), DW'(1));
      checkOutput("t2_data", out_data, DW'(36'h000ABC000));

      // Test 3: sparse valid, depth 3
      doReset(5'd3);
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1'b1, DW'(k * 10), 1'b0);
         checkOutput("t3_valid", DW'(out_valid), DW'(k >= 4));
         if (k >= 4) checkOutput("t3_data", out_data, DW'((k - 3) * 10));
         applyStimulus(1'b0, DW'(12'hEEE), 1'b0);
         checkOutput("t3_idle_valid", DW'(out_valid), DW'(0));
         checkOutput("t3_idle_fill", DW'(fill_cnt), DW'(k));
         if (k >= 4) checkOutput("t3_idle_hold", out_data, DW'((k - 3) * 10));
      end

      // Test 4: flush with a simultaneous sample, depth 2
      doReset(5'd2);
      for (int n = 1; n <= 6; n++) applyStimulus(1'b1, DW'(n), 1'b0);
      checkOutput("t4_pre_data", out_data, DW'(4));
      applyStimulus(1'b1, DW'(99), 1'b1);
      checkOutput("t4_flush_fill", DW'(fill_cnt), DW'(0));
      checkOutput("t4_flush_valid", DW'(out_valid), DW'(0));
      checkOutput("t4_flush_hold", out_data, DW'(4));
      applyStimulus(1'b1, DW'(101), 1'b0);
      checkOutput("t4_post1_valid", DW'(out_valid), DW'(0));
      applyStimulus(1'b1, DW'(102), 1'b0);
      checkOutput("t4_post2_valid", DW'(out_valid), DW'(0));
      applyStimulus(1'b1, DW'(103), 1'b0);
      checkOutput("t4_post3_valid", DW'(out_valid), DW'(1));
      checkOutput("t4_post3_data", out_data, DW'(101));

      // Test 5: out-of-range request clamps to 16, then shrink and grow
      doReset(5'd31);
      for (int n = 1; n <= 20; n++) begin
         applyStimulus(1'b1, DW'(n), 1'b0);
         checkOutput("t5_valid", DW'(out_valid), DW'(n >= 17));
         if (n >= 17) checkOutput("t5_data", out_data, DW'(n - 16));
      end
      dly_sel = 5'd2;
      applyStimulus(1'b1, DW'(21), 1'b0);
      checkOutput("t5_shrink_valid", DW'(out_valid), DW'(1));
      checkOutput("t5_shrink_data", out_data, DW'(19));
      dly_sel = 5'd8;
      applyStimulus(1'b1, DW'(22), 1'b0);
      checkOutput("t5_grow_valid", DW'(out_valid), DW'(1));
      checkOutput("t5_grow_data", out_data, DW'(14));
      checkOutput("t5_fill_sat", DW'(fill_cnt), DW'(16));

      // Test 6: channel isolation at depth 5, then reset mid-stream
      doReset(5'd5);
      for (int n = 1; n <= 6; n++) begin
         applyStimulus(1'b1, DW'(36'hFFF7FF001), 1'b0);
         checkOutput("t6_valid", DW'(out_valid), DW'(n == 6));
      end
      checkOutput("t6_data", out_data, DW'(36'hFFF7FF001));
      rst = 1'b1;
      applyStimulus(1'b1, DW'(36'h123456789), 1'b0);
      checkOutput("t6_rst_data", out_data, DW'(0));
      checkOutput("t6_rst_valid", DW'(out_valid), DW'(0));
      checkOutput("t6_rst_fill", DW'(fill_cnt), DW'(0));
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
